// File: rtl/wt_dcache_ctrl.sv
// wt_dcache_ctrl: load-port controller for a write-through data cache.
// Ports: clk_i/rst_i (async active-high reset); req_* load port from the core;
// miss_* request/return handshake with the miss unit; rd_* cache array
// read port; wr_cl_vld_i flags a concurrent line write that forces a replay.
module wt_dcache_ctrl #(
  parameter logic [1:0]  RdTxId     = 2'd1,
  parameter logic [55:0] CachedBase = 56'h0_8000_0000,
  parameter logic [55:0] CachedSize = 56'h0_4000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cache_en_i,
  input  logic [11:0] req_index_i,
  input  logic [43:0] req_tag_i,
  input  logic        req_data_req_i,
  input  logic [1:0]  req_data_size_i,
  input  logic        req_kill_i,
  input  logic        req_tag_valid_i,
  output logic        req_gnt_o,
  output logic        req_rvalid_o,
  output logic [63:0] req_rdata_o,
  output logic        miss_req_o,
  input  logic        miss_ack_i,
  input  logic        miss_replay_i,
  input  logic        miss_rtrn_vld_i,
  output logic        miss_we_o,
  output logic [63:0] miss_wdata_o,
  output logic        miss_nc_o,
  output logic [2:0]  miss_size_o,
  output logic [1:0]  miss_id_o,
  output logic [55:0] miss_paddr_o,
  output logic [7:0]  miss_vld_bits_o,
  input  logic        wr_cl_vld_i,
  output logic        rd_req_o,
  input  logic        rd_ack_i,
  output logic        rd_tag_only_o,
  output logic [7:0]  rd_idx_o,
  output logic [3:0]  rd_off_o,
  output logic [43:0] rd_tag_o,
  input  logic [63:0] rd_data_i,
  input  logic [7:0]  rd_vld_bits_i,
  input  logic [7:0]  rd_hit_oh_i
);
  localparam logic [2:0] IDLE          = 3'd0;
  localparam logic [2:0] READ          = 3'd1;
  localparam logic [2:0] MISS_REQ      = 3'd2;
  localparam logic [2:0] MISS_WAIT     = 3'd3;
  localparam logic [2:0] KILL_MISS_ACK = 3'd4;
  localparam logic [2:0] KILL_MISS     = 3'd5;
  localparam logic [2:0] REPLAY_REQ    = 3'd6;
  localparam logic [2:0] REPLAY_READ   = 3'd7;
  logic [2:0]  state_q, state_d;
  logic [11:0] idx_q;
  logic [43:0] tag_q;
  logic [1:0]  size_q;
  logic [7:0]  vld_q;
  logic        gnt, rvalid, mreq, rreq, in_range;
  logic [55:0] paddr;
  always_comb begin
    state_d = state_q;
    gnt     = 1'b0;
    rvalid  = 1'b0;
    mreq    = 1'b0;
    rreq    = 1'b0;
    case (state_q)
      IDLE: begin
        rreq = req_data_req_i;
        if (req_data_req_i && rd_ack_i) begin
          gnt     = 1'b1;
          state_d = READ;
        end
      end
      READ, REPLAY_READ: begin
        if (req_kill_i) begin
          rvalid  = 1'b1;
          state_d = IDLE;
        end else if (wr_cl_vld_i) begin
          state_d = REPLAY_REQ;
        end else if (|rd_hit_oh_i && cache_en_i) begin
          // a hit may accept the next load in the same cycle
          rvalid  = 1'b1;
          rreq    = req_data_req_i;
          gnt     = req_data_req_i && rd_ack_i;
          state_d = gnt ? READ : IDLE;
        end else begin
          state_d = MISS_REQ;
        end
      end
      MISS_REQ: begin
        mreq = 1'b1;
        if (req_kill_i) begin
          rvalid  = 1'b1;
          state_d = miss_ack_i ? IDLE : KILL_MISS_ACK;
        end else if (miss_replay_i) begin
          state_d = REPLAY_REQ;
        end else if (miss_ack_i) begin
          state_d = MISS_WAIT;
        end
      end
      MISS_WAIT: begin
        if (miss_rtrn_vld_i) begin
          rvalid  = 1'b1;
          state_d = IDLE;
        end else if (req_kill_i) begin
          rvalid  = 1'b1;
          state_d = KILL_MISS;
        end
      end
      // the killed load already got its rvalid; just drain the miss unit
      KILL_MISS_ACK: begin
        mreq    = 1'b1;
        state_d = miss_replay_i ? IDLE : miss_ack_i ? KILL_MISS : state_q;
      end
      KILL_MISS: state_d = miss_rtrn_vld_i ? IDLE : state_q;
      REPLAY_REQ: begin
        rreq = 1'b1;
        if (req_kill_i) begin
          rvalid  = 1'b1;
          state_d = IDLE;
        end else if (rd_ack_i) begin
          state_d = REPLAY_READ;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      tag_q   <= '0;
      size_q  <= '0;
      vld_q   <= '0;
    end else begin
      state_q <= state_d;
      if (req_gnt_o) begin
        idx_q  <= req_index_i;
        size_q <= req_data_size_i;
      end
      if (req_tag_valid_i) tag_q <= req_tag_i;
      if (state_q == READ || state_q == REPLAY_READ) vld_q <= rd_vld_bits_i;
    end
  end
  // handshakes are combinational from the idle state, so hold them low in reset
  assign req_gnt_o       = gnt & ~rst_i;
  assign req_rvalid_o    = rvalid & ~rst_i;
  assign miss_req_o      = mreq & ~rst_i;
  assign rd_req_o        = rreq & ~rst_i;
  assign req_rdata_o     = rd_data_i;
  assign rd_idx_o        = state_q == IDLE ? req_index_i[11:4] : idx_q[11:4];
  assign rd_off_o        = state_q == IDLE ? req_index_i[3:0] : idx_q[3:0];
  assign rd_tag_o        = state_q == READ ? req_tag_i : tag_q;
  assign rd_tag_only_o   = 1'b0;
  assign paddr           = {tag_q, idx_q};
  assign in_range        = paddr >= CachedBase && paddr < CachedBase + CachedSize;
  assign miss_nc_o       = ~cache_en_i | ~in_range;
  assign miss_size_o     = miss_nc_o ? {1'b0, size_q} : 3'b111;
  assign miss_id_o       = RdTxId;
  assign miss_paddr_o    = paddr;
  assign miss_vld_bits_o = vld_q;
  assign miss_we_o       = 1'b0;
  assign miss_wdata_o    = '0;
endmodule

// File: tb/tb_wt_dcache_ctrl.sv
// tb_wt_dcache_ctrl: scoreboard bench for the cache load controller.
module tb_wt_dcache_ctrl;
  logic        clk_i = 1'b0, rst_i;
  logic        cache_en_i, req_data_req_i, req_kill_i, req_tag_valid_i;
  logic [11:0] req_index_i;
  logic [43:0] req_tag_i;
  logic [1:0]  req_data_size_i;
  logic        req_gnt_o, req_rvalid_o, miss_req_o, miss_we_o, miss_nc_o;
  logic [63:0] req_rdata_o, miss_wdata_o, rd_data_i;
  logic        miss_ack_i, miss_replay_i, miss_rtrn_vld_i, wr_cl_vld_i;
  logic [2:0]  miss_size_o;
  logic [1:0]  miss_id_o;
  logic [55:0] miss_paddr_o;
  logic [7:0]  miss_vld_bits_o, rd_idx_o, rd_vld_bits_i, rd_hit_oh_i;
  logic        rd_req_o, rd_ack_i, rd_tag_only_o;
  logic [3:0]  rd_off_o;
  logic [43:0] rd_tag_o;
  int checks = 0, errors = 0;
  logic [63:0] rq[$];
  logic [69:0] mq[$];
  always #5 clk_i = ~clk_i;
  wt_dcache_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .cache_en_i(cache_en_i), .req_index_i(req_index_i),
    .req_tag_i(req_tag_i), .req_data_req_i(req_data_req_i), .req_data_size_i(req_data_size_i),
    .req_kill_i(req_kill_i), .req_tag_valid_i(req_tag_valid_i), .req_gnt_o(req_gnt_o),
    .req_rvalid_o(req_rvalid_o), .req_rdata_o(req_rdata_o), .miss_req_o(miss_req_o),
    .miss_ack_i(miss_ack_i), .miss_replay_i(miss_replay_i), .miss_rtrn_vld_i(miss_rtrn_vld_i),
    .miss_we_o(miss_we_o), .miss_wdata_o(miss_wdata_o), .miss_nc_o(miss_nc_o),
    .miss_size_o(miss_size_o), .miss_id_o(miss_id_o), .miss_paddr_o(miss_paddr_o),
    .miss_vld_bits_o(miss_vld_bits_o), .wr_cl_vld_i(wr_cl_vld_i), .rd_req_o(rd_req_o),
    .rd_ack_i(rd_ack_i), .rd_tag_only_o(rd_tag_only_o), .rd_idx_o(rd_idx_o),
    .rd_off_o(rd_off_o), .rd_tag_o(rd_tag_o), .rd_data_i(rd_data_i),
    .rd_vld_bits_i(rd_vld_bits_i), .rd_hit_oh_i(rd_hit_oh_i)
  );
  task automatic chk(input string n, input logic [69:0] a, input logic [69:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  // every rvalid must match a queued response; every accepted miss a queued miss
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (req_rvalid_o) begin
        if (rq.size() == 0) chk("unexpected_rvalid", 70'(1), 70'(0));
        else chk("rdata", 70'(req_rdata_o), 70'(rq.pop_front()));
      end
      if (miss_req_o && miss_ack_i) begin
        if (mq.size() == 0) chk("unexpected_miss", 70'(1), 70'(0));
        else chk("miss", {miss_nc_o, miss_size_o, miss_id_o, miss_paddr_o, miss_vld_bits_o}, mq.pop_front());
      end
    end
  end
  task automatic clear();
    cache_en_i = 1'b1; req_index_i = '0; req_tag_i = '0; req_data_req_i = 1'b0;
    req_data_size_i = '0; req_kill_i = 1'b0; req_tag_valid_i = 1'b0; miss_ack_i = 1'b0;
    miss_replay_i = 1'b0; miss_rtrn_vld_i = 1'b0; wr_cl_vld_i = 1'b0; rd_ack_i = 1'b0;
    rd_data_i = '0; rd_vld_bits_i = '0; rd_hit_oh_i = '0;
  endtask
  task automatic go();
    @(posedge clk_i);
    #1;
    clear();
  endtask
  task automatic grant(input logic [11:0] idx, input logic [1:0] sz);
    go();
    req_data_req_i = 1'b1; req_index_i = idx; req_data_size_i = sz; rd_ack_i = 1'b1;
    #1 chk("gnt", 70'(req_gnt_o), 70'(1));
  endtask
  task automatic read_miss(input logic [43:0] tag, input logic [7:0] vld);
    go();
    req_tag_i = tag; req_tag_valid_i = 1'b1; rd_vld_bits_i = vld;
  endtask
  initial begin
    clear();
    rst_i = 1'b1; req_data_req_i = 1'b1; rd_ack_i = 1'b1; miss_ack_i = 1'b1;
    #3;
    chk("rst_gnt", 70'(req_gnt_o), 70'(0));
    chk("rst_rvalid", 70'(req_rvalid_o), 70'(0));
    chk("rst_miss_req", 70'(miss_req_o), 70'(0));
    chk("rst_rd_req", 70'(rd_req_o), 70'(0));
    chk("rst_paddr", 70'(miss_paddr_o), 70'(0));
    go();
    rst_i = 1'b0;
    // hit
    grant(12'h010, 2'd3);
    chk("hit_rd_idx", 70'(rd_idx_o), 70'(8'h01));
    chk("hit_rd_off", 70'(rd_off_o), 70'(0));
    go();
    req_tag_i = 44'h80000; req_tag_valid_i = 1'b1; rd_hit_oh_i = 8'h01;
    rd_data_i = 64'h1111_2222_3333_4444; rq.push_back(64'h1111_2222_3333_4444);
    #1 chk("hit_rd_tag", 70'(rd_tag_o), 70'(44'h80000));
    // cached miss
    grant(12'h010, 2'd3);
    read_miss(44'h80000, 8'h5A);
    go();
    miss_ack_i = 1'b1; mq.push_back({1'b0, 3'b111, 2'd1, 56'h80000010, 8'h5A});
    go();
    #1 chk("wait_no_rvalid", 70'(req_rvalid_o), 70'(0));
    go();
    miss_rtrn_vld_i = 1'b1; rd_data_i = 64'hA5A5_0000_0000_0002; rq.push_back(64'hA5A5_0000_0000_0002);
    // non-cacheable address
    grant(12'h000, 2'd3);
    read_miss(44'h10000, 8'hFF);
    go();
    miss_ack_i = 1'b1; mq.push_back({1'b1, 3'b011, 2'd1, 56'h10000000, 8'hFF});
    go();
    miss_rtrn_vld_i = 1'b1; rd_data_i = 64'h3; rq.push_back(64'h3);
    // cache disabled: hit vector ignored, miss is non-cacheable
    grant(12'h040, 2'd1);
    go();
    cache_en_i = 1'b0; req_tag_i = 44'h80000; req_tag_valid_i = 1'b1; rd_hit_oh_i = 8'h01; rd_vld_bits_i = 8'h03;
    go();
    cache_en_i = 1'b0; miss_ack_i = 1'b1; mq.push_back({1'b1, 3'b001, 2'd1, 56'h80000040, 8'h03});
    go();
    cache_en_i = 1'b0; miss_rtrn_vld_i = 1'b1; rd_data_i = 64'h4; rq.push_back(64'h4);
    // kill while waiting for the miss return
    grant(12'h010, 2'd2);
    read_miss(44'h80001, 8'h00);
    go();
    miss_ack_i = 1'b1; mq.push_back({1'b0, 3'b111, 2'd1, 56'h80001010, 8'h00});
    go();
    req_kill_i = 1'b1; rd_data_i = 64'h5; rq.push_back(64'h5);
    go();
    go();
    miss_rtrn_vld_i = 1'b1; rd_data_i = 64'hBAD;
    // readout collision and replay
    grant(12'h030, 2'd3);
    go();
    req_tag_i = 44'h80000; req_tag_valid_i = 1'b1; rd_hit_oh_i = 8'h01; wr_cl_vld_i = 1'b1; rd_data_i = 64'hBAD;
    go();
    req_tag_i = 44'hDEAD;
    #1;
    chk("replay_rd_req", 70'(rd_req_o), 70'(1));
    chk("replay_rd_tag", 70'(rd_tag_o), 70'(44'h80000));
    chk("replay_rd_idx", 70'(rd_idx_o), 70'(8'h03));
    go();
    rd_ack_i = 1'b1;
    go();
    rd_hit_oh_i = 8'h04; rd_data_i = 64'h6; rq.push_back(64'h6);
    // back-to-back hits
    grant(12'h010, 2'd3);
    go();
    req_tag_i = 44'h80000; req_tag_valid_i = 1'b1; rd_hit_oh_i = 8'h01;
    req_data_req_i = 1'b1; req_index_i = 12'h020; rd_ack_i = 1'b1;
    rd_data_i = 64'h7; rq.push_back(64'h7);
    #1 chk("b2b_gnt", 70'(req_gnt_o), 70'(1));
    go();
    req_tag_i = 44'h80000; req_tag_valid_i = 1'b1; rd_hit_oh_i = 8'h02;
    rd_data_i = 64'h8; rq.push_back(64'h8);
    #1 chk("b2b_rd_idx", 70'(rd_idx_o), 70'(8'h02));
    // kill in READ
    grant(12'h010, 2'd3);
    go();
    req_kill_i = 1'b1; rd_data_i = 64'h9; rq.push_back(64'h9);
    // kill in MISS_REQ before ack, then drain the miss
    grant(12'h050, 2'd3);
    read_miss(44'h80000, 8'h0F);
    go();
    req_kill_i = 1'b1; rd_data_i = 64'hA; rq.push_back(64'hA);
    go();
    miss_ack_i = 1'b1; mq.push_back({1'b0, 3'b111, 2'd1, 56'h80000050, 8'h0F});
    go();
    miss_rtrn_vld_i = 1'b1; rd_data_i = 64'hBAD;
    grant(12'h000, 2'd0);
    go();
    req_kill_i = 1'b1; rd_data_i = 64'hB; rq.push_back(64'hB);
    go();
    go();
    chk("rq_drained", 70'(rq.size()), 70'(0));
    chk("mq_drained", 70'(mq.size()), 70'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
